// File: rtl/pipe_hazard_ctrl.sv
// Hazard, forwarding and halt-drain controller for the five-stage core.
// A shift-register scoreboard tracks in-flight destinations from EX (slot 1)
// to WB (slot DEPTH). Stall, flush, issue and forwarding selects are derived
// combinationally from the scoreboard and the instruction sitting in ID.
module pipe_hazard_ctrl #(
  parameter int unsigned REG_ADDR_W = 5,
  parameter int unsigned DEPTH      = 3,
  parameter int unsigned FWD_EN     = 1,
  parameter int unsigned LOAD_LAT   = 1
) (
  input  logic                         clk,
  input  logic                         rst_b,
  input  logic                         id_valid,
  input  logic [REG_ADDR_W-1:0]        id_rs,
  input  logic [REG_ADDR_W-1:0]        id_rt,
  input  logic                         id_rs_used,
  input  logic                         id_rt_used,
  input  logic [REG_ADDR_W-1:0]        id_rd,
  input  logic                         id_rd_we,
  input  logic                         id_is_load,
  input  logic                         id_halt,
  input  logic                         ex_redirect,
  output logic                         stall,
  output logic                         flush_if_id,
  output logic                         flush_id_ex,
  output logic                         issue,
  output logic [$clog2(DEPTH+1)-1:0]   fwd_rs_sel,
  output logic [$clog2(DEPTH+1)-1:0]   fwd_rt_sel,
  output logic                         halted
);

  localparam int unsigned SelW = $clog2(DEPTH + 1);
  localparam int unsigned CntW = $clog2(DEPTH);

  typedef enum logic [1:0] {StRun, StDrain, StHalted} state_e;

  // Scoreboard, slot 1 = EX ... slot DEPTH = WB. The halt itself is tracked
  // by the drain counter rather than by a per-slot flag.
  logic                  slot_v_q    [1:DEPTH];
  logic [REG_ADDR_W-1:0] slot_rd_q   [1:DEPTH];
  logic                  slot_we_q   [1:DEPTH];
  logic                  slot_load_q [1:DEPTH];

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;

  logic            hazard;
  logic [SelW-1:0] rs_sel, rt_sel;

  // Source matching: walk oldest to youngest so the youngest writer wins.
  always_comb begin
    hazard = 1'b0;
    rs_sel = '0;
    rt_sel = '0;
    for (int k = int'(DEPTH); k >= 1; k--) begin
      if (slot_v_q[k] && slot_we_q[k] && (slot_rd_q[k] != '0)) begin
        if (id_rs_used && (slot_rd_q[k] == id_rs)) begin
          rs_sel = SelW'(k);
          if ((FWD_EN == 0) || ((k <= int'(LOAD_LAT)) && slot_load_q[k])) hazard = 1'b1;
        end
        if (id_rt_used && (slot_rd_q[k] == id_rt)) begin
          rt_sel = SelW'(k);
          if ((FWD_EN == 0) || ((k <= int'(LOAD_LAT)) && slot_load_q[k])) hazard = 1'b1;
        end
      end
    end
  end

  // Pipeline control outputs and drain FSM next state; reset masks every output.
  always_comb begin
    stall       = 1'b0;
    flush_if_id = 1'b0;
    flush_id_ex = 1'b0;
    issue       = 1'b0;
    halted      = 1'b0;
    fwd_rs_sel  = (FWD_EN != 0) ? rs_sel : '0;
    fwd_rt_sel  = (FWD_EN != 0) ? rt_sel : '0;
    state_d     = state_q;
    cnt_d       = cnt_q;
    unique case (state_q)
      StRun: begin
        if (ex_redirect) begin
          // Redirect beats stall; a halt in ID is dropped with the flush.
          flush_if_id = 1'b1;
          flush_id_ex = 1'b1;
        end else begin
          stall = hazard;
          issue = id_valid & ~hazard;
        end
        if (issue && id_halt) begin
          state_d = StDrain;
          cnt_d   = CntW'(DEPTH - 1);
        end
      end
      StDrain: begin
        stall = 1'b1;
        if (cnt_q == '0) begin
          state_d = StHalted;
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      StHalted: begin
        stall  = 1'b1;
        halted = 1'b1;
      end
      default: state_d = StRun;
    endcase
    if (rst_b) begin
      stall       = 1'b0;
      flush_if_id = 1'b0;
      flush_id_ex = 1'b0;
      issue       = 1'b0;
      halted      = 1'b0;
      fwd_rs_sel  = '0;
      fwd_rt_sel  = '0;
    end
  end

  // Scoreboard shift, FSM state and drain counter registers.
  always_ff @(posedge clk) begin
    if (rst_b) begin
      for (int k = 1; k <= int'(DEPTH); k++) begin
        slot_v_q[k]    <= 1'b0;
        slot_rd_q[k]   <= '0;
        slot_we_q[k]   <= 1'b0;
        slot_load_q[k] <= 1'b0;
      end
      state_q <= StRun;
      cnt_q   <= '0;
    end else begin
      slot_v_q[1]    <= issue;
      slot_rd_q[1]   <= id_rd;
      slot_we_q[1]   <= id_rd_we;
      slot_load_q[1] <= id_is_load;
      for (int k = 2; k <= int'(DEPTH); k++) begin
        slot_v_q[k]    <= slot_v_q[k-1];
        slot_rd_q[k]   <= slot_rd_q[k-1];
        slot_we_q[k]   <= slot_we_q[k-1];
        slot_load_q[k] <= slot_load_q[k-1];
      end
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: directed vector table on the forwarding
// instance, a hand sequence on a non-forwarding instance, then random
// stimulus on both against an issue-history reference model.
module tb_pipe_hazard_ctrl;

  localparam int D  = 3;
  localparam int LL = 1;
  localparam int NV = 23;

  logic       clk;
  logic       rst_b;
  logic       id_valid;
  logic [4:0] id_rs, id_rt, id_rd;
  logic       id_rs_used, id_rt_used, id_rd_we, id_is_load, id_halt, ex_redirect;

  logic       stall, flush_if_id, flush_id_ex, issue, halted;
  logic [1:0] fwd_rs_sel, fwd_rt_sel;
  logic       stall_nf, flush_if_id_nf, flush_id_ex_nf, issue_nf, halted_nf;
  logic [1:0] fwd_rs_sel_nf, fwd_rt_sel_nf;

  int n_checks = 0;
  int n_errors = 0;

  pipe_hazard_ctrl #(.REG_ADDR_W(5), .DEPTH(D), .FWD_EN(1), .LOAD_LAT(LL)) dut (
    .clk(clk), .rst_b(rst_b), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_rs_used(id_rs_used), .id_rt_used(id_rt_used), .id_rd(id_rd), .id_rd_we(id_rd_we),
    .id_is_load(id_is_load), .id_halt(id_halt), .ex_redirect(ex_redirect), .stall(stall),
    .flush_if_id(flush_if_id), .flush_id_ex(flush_id_ex), .issue(issue),
    .fwd_rs_sel(fwd_rs_sel), .fwd_rt_sel(fwd_rt_sel), .halted(halted)
  );

  pipe_hazard_ctrl #(.REG_ADDR_W(5), .DEPTH(D), .FWD_EN(0), .LOAD_LAT(LL)) dut_nf (
    .clk(clk), .rst_b(rst_b), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_rs_used(id_rs_used), .id_rt_used(id_rt_used), .id_rd(id_rd), .id_rd_we(id_rd_we),
    .id_is_load(id_is_load), .id_halt(id_halt), .ex_redirect(ex_redirect), .stall(stall_nf),
    .flush_if_id(flush_if_id_nf), .flush_id_ex(flush_id_ex_nf), .issue(issue_nf),
    .fwd_rs_sel(fwd_rs_sel_nf), .fwd_rt_sel(fwd_rt_sel_nf), .halted(halted_nf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rst, valid;
    logic [4:0] rs, rt;
    logic       ru, tu;
    logic [4:0] rd;
    logic       we, ld, ht, rdr;
    logic       e_stall, e_fif, e_fex, e_issue;
    logic [1:0] e_frs, e_frt;
    logic       e_halted;
  } vec_t;

  vec_t vecs [NV];

  typedef struct {
    int m;
    int edge_no;
    int rd;
    int we;
    int load;
  } iss_t;

  typedef struct {
    int stall, fif, fex, issue, halted, frs, frt;
  } exp_t;

  iss_t hist[$];
  int   halt_edge [2];
  int   ecnt;

  task automatic check(input string name, input int idx, input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s[%0d]: got %0h, expected %0h", name, idx, act, exp);
    end
  endtask

  function automatic vec_t mkv(input int rst, input int v, input int rs, input int rt,
                               input int ru, input int tu, input int rd, input int we,
                               input int ld, input int ht, input int rdr, input int st,
                               input int fi, input int fe, input int is, input int frs,
                               input int frt, input int hl);
    vec_t x;
    x.rst = rst[0];  x.valid = v[0];   x.rs = rs[4:0];  x.rt = rt[4:0];
    x.ru = ru[0];    x.tu = tu[0];     x.rd = rd[4:0];  x.we = we[0];
    x.ld = ld[0];    x.ht = ht[0];     x.rdr = rdr[0];
    x.e_stall = st[0]; x.e_fif = fi[0]; x.e_fex = fe[0]; x.e_issue = is[0];
    x.e_frs = frs[1:0]; x.e_frt = frt[1:0]; x.e_halted = hl[0];
    return x;
  endfunction

  task automatic drive(input logic r, input logic v, input logic [4:0] rs, input logic [4:0] rt,
                       input logic ru, input logic tu, input logic [4:0] rd, input logic we,
                       input logic ld, input logic ht, input logic rdr);
    rst_b = r;  id_valid = v;  id_rs = rs;  id_rt = rt;  id_rs_used = ru;  id_rt_used = tu;
    id_rd = rd; id_rd_we = we; id_is_load = ld; id_halt = ht; ex_redirect = rdr;
  endtask

  // Expected outputs from the issue history: an instruction issued at edge x
  // sits in slot ecnt-x+1; halted once DEPTH edges have passed since the halt.
  function automatic exp_t model(input int m);
    exp_t e;
    int   fwd_en, slot, frs, frt, haz, hnow, drn;
    e = '{default: 0};
    if (rst_b) return e;
    fwd_en = (m == 0) ? 1 : 0;
    hnow = (halt_edge[m] >= 0 && ecnt >= halt_edge[m] + D) ? 1 : 0;
    drn  = (halt_edge[m] >= 0 && hnow == 0) ? 1 : 0;
    haz = 0; frs = 0; frt = 0;
    foreach (hist[i]) begin
      if (hist[i].m == m) begin
        slot = ecnt - hist[i].edge_no + 1;
        if (slot >= 1 && slot <= D && hist[i].we != 0 && hist[i].rd != 0) begin
          if (id_rs_used && hist[i].rd == int'(id_rs)) begin
            if (frs == 0 || slot < frs) frs = slot;
            if (fwd_en == 0 || (hist[i].load != 0 && slot <= LL)) haz = 1;
          end
          if (id_rt_used && hist[i].rd == int'(id_rt)) begin
            if (frt == 0 || slot < frt) frt = slot;
            if (fwd_en == 0 || (hist[i].load != 0 && slot <= LL)) haz = 1;
          end
        end
      end
    end
    if (drn != 0 || hnow != 0) begin
      e.stall  = 1;
      e.halted = hnow;
    end else if (ex_redirect) begin
      e.fif = 1;
      e.fex = 1;
    end else begin
      e.stall = haz;
      e.issue = (id_valid && haz == 0) ? 1 : 0;
    end
    e.frs = fwd_en != 0 ? frs : 0;
    e.frt = fwd_en != 0 ? frt : 0;
    return e;
  endfunction

  task automatic model_edge(input exp_t e0, input exp_t e1);
    exp_t e [2];
    e[0] = e0;
    e[1] = e1;
    ecnt++;
    for (int m = 0; m < 2; m++) begin
      if (rst_b) begin
        for (int i = hist.size() - 1; i >= 0; i--) if (hist[i].m == m) hist.delete(i);
        halt_edge[m] = -1;
      end else if (e[m].issue != 0) begin
        hist.push_back('{m: m, edge_no: ecnt, rd: int'(id_rd), we: int'(id_rd_we),
                         load: int'(id_is_load)});
        if (id_halt) halt_edge[m] = ecnt;
      end
    end
    for (int i = hist.size() - 1; i >= 0; i--) if (ecnt - hist[i].edge_no + 1 > D) hist.delete(i);
  endtask

  task automatic cmp_model(input int m, input int idx, input exp_t e);
    if (m == 0) begin
      check("rnd.stall", idx, 32'(stall), e.stall);
      check("rnd.fif", idx, 32'(flush_if_id), e.fif);
      check("rnd.fex", idx, 32'(flush_id_ex), e.fex);
      check("rnd.issue", idx, 32'(issue), e.issue);
      check("rnd.halted", idx, 32'(halted), e.halted);
      if (e.stall == 0) begin
        check("rnd.frs", idx, 32'(fwd_rs_sel), e.frs);
        check("rnd.frt", idx, 32'(fwd_rt_sel), e.frt);
      end
    end else begin
      check("rnd_nf.stall", idx, 32'(stall_nf), e.stall);
      check("rnd_nf.fif", idx, 32'(flush_if_id_nf), e.fif);
      check("rnd_nf.fex", idx, 32'(flush_id_ex_nf), e.fex);
      check("rnd_nf.issue", idx, 32'(issue_nf), e.issue);
      check("rnd_nf.halted", idx, 32'(halted_nf), e.halted);
      check("rnd_nf.frs", idx, 32'(fwd_rs_sel_nf), e.frs);
      check("rnd_nf.frt", idx, 32'(fwd_rt_sel_nf), e.frt);
    end
  endtask

  initial begin
    exp_t e0, e1;
    //              rst v rs rt ru tu rd we ld ht rdr | st fi fe is frs frt hl
    vecs[0]  = mkv(1, 1, 8, 8, 1, 1, 8, 1, 1, 0, 1,   0, 0, 0, 0, 0, 0, 0);
    vecs[1]  = mkv(0, 1, 1, 0, 1, 0, 8, 1, 1, 0, 0,   0, 0, 0, 1, 0, 0, 0); // lw r8
    vecs[2]  = mkv(0, 1, 8, 8, 1, 1, 9, 1, 0, 0, 0,   1, 0, 0, 0, 0, 0, 0); // load-use
    vecs[3]  = mkv(0, 1, 8, 8, 1, 1, 9, 1, 0, 0, 0,   0, 0, 0, 1, 2, 2, 0);
    vecs[4]  = mkv(0, 1, 9, 3, 1, 1, 10, 1, 0, 0, 0,  0, 0, 0, 1, 1, 0, 0); // ALU b2b
    vecs[5]  = mkv(0, 1, 1, 2, 1, 1, 9, 1, 0, 0, 0,   0, 0, 0, 1, 0, 0, 0);
    vecs[6]  = mkv(0, 1, 9, 10, 1, 1, 11, 1, 0, 0, 0, 0, 0, 0, 1, 1, 2, 0); // youngest
    vecs[7]  = mkv(0, 1, 11, 0, 1, 1, 0, 1, 1, 0, 0,  0, 0, 0, 1, 1, 0, 0); // lw r0
    vecs[8]  = mkv(0, 1, 0, 0, 1, 1, 5, 1, 0, 0, 0,   0, 0, 0, 1, 0, 0, 0); // r0 no fwd
    vecs[9]  = mkv(0, 1, 1, 0, 1, 0, 12, 1, 1, 0, 0,  0, 0, 0, 1, 0, 0, 0); // lw r12
    vecs[10] = mkv(0, 1, 12, 5, 1, 1, 13, 1, 0, 0, 1, 0, 1, 1, 0, 1, 2, 0); // redirect
    vecs[11] = mkv(0, 1, 12, 5, 1, 1, 14, 1, 0, 0, 0, 0, 0, 0, 1, 2, 3, 0); // slot1 empty
    vecs[12] = mkv(0, 1, 1, 0, 0, 0, 0, 0, 0, 1, 0,   0, 0, 0, 1, 0, 0, 0); // halt at t
    vecs[13] = mkv(0, 1, 1, 2, 1, 1, 15, 1, 0, 0, 0,  1, 0, 0, 0, 0, 0, 0);
    vecs[14] = mkv(0, 1, 1, 2, 1, 1, 15, 1, 0, 0, 0,  1, 0, 0, 0, 0, 0, 0);
    vecs[15] = mkv(0, 1, 1, 2, 1, 1, 15, 1, 0, 0, 0,  1, 0, 0, 0, 0, 0, 0); // t+2
    vecs[16] = mkv(0, 1, 1, 2, 1, 1, 15, 1, 0, 0, 1,  1, 0, 0, 0, 0, 0, 1); // t+3
    vecs[17] = mkv(0, 1, 1, 2, 1, 1, 15, 1, 0, 0, 0,  1, 0, 0, 0, 0, 0, 1);
    vecs[18] = mkv(1, 1, 8, 8, 1, 1, 8, 1, 1, 1, 0,   0, 0, 0, 0, 0, 0, 0);
    vecs[19] = mkv(0, 0, 1, 2, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0, 0);
    vecs[20] = mkv(0, 1, 1, 0, 0, 0, 0, 0, 0, 1, 0,   0, 0, 0, 1, 0, 0, 0); // halt
    vecs[21] = mkv(1, 1, 1, 2, 1, 1, 6, 1, 0, 0, 0,   0, 0, 0, 0, 0, 0, 0); // mid-drain
    vecs[22] = mkv(0, 1, 1, 2, 1, 1, 6, 1, 0, 0, 0,   0, 0, 0, 1, 0, 0, 0);

    drive(1'b1, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #1;

    for (int r = 0; r < NV; r++) begin
      drive(vecs[r].rst, vecs[r].valid, vecs[r].rs, vecs[r].rt, vecs[r].ru, vecs[r].tu,
            vecs[r].rd, vecs[r].we, vecs[r].ld, vecs[r].ht, vecs[r].rdr);
      #2;
      check("vec.stall", r, 32'(stall), 32'(vecs[r].e_stall));
      check("vec.fif", r, 32'(flush_if_id), 32'(vecs[r].e_fif));
      check("vec.fex", r, 32'(flush_id_ex), 32'(vecs[r].e_fex));
      check("vec.issue", r, 32'(issue), 32'(vecs[r].e_issue));
      check("vec.halted", r, 32'(halted), 32'(vecs[r].e_halted));
      if (!vecs[r].e_stall) begin
        check("vec.frs", r, 32'(fwd_rs_sel), 32'(vecs[r].e_frs));
        check("vec.frt", r, 32'(fwd_rt_sel), 32'(vecs[r].e_frt));
      end
      @(posedge clk);
      #1;
    end

    // Non-forwarding instance: add r8, then add r9,r8,r0 waits for write-back.
    drive(1'b1, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    #2;
    check("nf.rst_stall", 0, 32'(stall_nf), 32'd0);
    @(posedge clk);
    #1;
    drive(1'b0, 1'b1, 5'd1, 5'd2, 1'b0, 1'b0, 5'd8, 1'b1, 1'b0, 1'b0, 1'b0);
    #2;
    check("nf.issue_first", 0, 32'(issue_nf), 32'd1);
    @(posedge clk);
    #1;
    drive(1'b0, 1'b1, 5'd8, 5'd0, 1'b1, 1'b1, 5'd9, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int c = 0; c < 3; c++) begin
      #2;
      check("nf.stall", c, 32'(stall_nf), 32'd1);
      check("nf.no_issue", c, 32'(issue_nf), 32'd0);
      @(posedge clk);
      #1;
    end
    #2;
    check("nf.stall_end", 3, 32'(stall_nf), 32'd0);
    check("nf.issue_end", 3, 32'(issue_nf), 32'd1);
    check("nf.frs_end", 3, 32'(fwd_rs_sel_nf), 32'd0);
    @(posedge clk);
    #1;

    // Random phase, both instances against the reference model.
    ecnt = 0;
    hist.delete();
    halt_edge[0] = -1;
    halt_edge[1] = -1;
    for (int c = 0; c < 3000; c++) begin
      drive((c == 0) || ($urandom_range(0, 63) == 0),
            $urandom_range(0, 3) != 0,
            5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            5'($urandom_range(0, 7)),
            $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0,
            $urandom_range(0, 39) == 0, $urandom_range(0, 9) == 0);
      #2;
      e0 = model(0);
      e1 = model(1);
      cmp_model(0, c, e0);
      cmp_model(1, c, e1);
      @(posedge clk);
      model_edge(e0, e1);
      #1;
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
